// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider and its EX-stage issue controller.
package div_pkg;

   // Operand width the divider is built for, and the default ready watchdog limit.
   localparam int DIV_WIDTH   = 32;
   localparam int DIV_TIMEOUT = 40;

   // Divider internal state codes.
   localparam logic [1:0] DIV_FREE    = 2'b00;
   localparam logic [1:0] DIV_BY_ZERO = 2'b01;
   localparam logic [1:0] DIV_ON      = 2'b10;
   localparam logic [1:0] DIV_END     = 2'b11;

   // Start/stop level driven to the divider.
   localparam logic DIV_START = 1'b1;
   localparam logic DIV_STOP  = 1'b0;

   // Result-valid level returned by the divider.
   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;

   // Issue controller states.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } ctrl_state_t;

endpackage

// File: rtl/div_issue_ctrl.sv
// EX-stage initiator for the iterative divider. Latches DIV/DIVU operands, holds
// them on the divider inputs for the whole operation, stalls the pipeline while
// the divider works and issues a single HI/LO write. A flush aborts the divide;
// a watchdog flags a divider that never answers.
module div_issue_ctrl
   import div_pkg::*;
#(
   parameter int TIMEOUT = DIV_TIMEOUT,
   parameter int WIDTH   = DIV_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_i,
   input  logic               signed_i,
   input  logic [WIDTH-1:0]   rs_i,
   input  logic [WIDTH-1:0]   rt_i,
   input  logic               flush_i,
   output logic               stall_req_o,
   output logic               hilo_we_o,
   output logic [WIDTH-1:0]   hi_o,
   output logic [WIDTH-1:0]   lo_o,
   output logic               div_start_o,
   output logic               div_flush_o,
   output logic               div_signed_o,
   output logic [WIDTH-1:0]   div_op1_o,
   output logic [WIDTH-1:0]   div_op2_o,
   input  logic [2*WIDTH-1:0] div_result_i,
   input  logic               div_ready_i,
   output logic               div_timeout_o
);

   localparam int               CNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   ctrl_state_t      state_reg;
   logic             start_reg;
   logic             signed_reg;
   logic [WIDTH-1:0] op1_reg;
   logic [WIDTH-1:0] op2_reg;
   logic [WIDTH-1:0] hi_reg;
   logic [WIDTH-1:0] lo_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             timeout_reg;

   // Controller FSM with operand latches, result capture and ready watchdog.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         start_reg   <= DIV_STOP;
         signed_reg  <= 1'b0;
         op1_reg     <= '0;
         op2_reg     <= '0;
         hi_reg      <= '0;
         lo_reg      <= '0;
         cnt_reg     <= '0;
         timeout_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               // Operands are only captured here, so they stay stable on the
               // divider inputs until the controller is back in IDLE.
               if (req_i && !flush_i) begin
                  signed_reg <= signed_i;
                  op1_reg    <= rs_i;
                  op2_reg    <= rt_i;
                  start_reg  <= DIV_START;
                  cnt_reg    <= '0;
                  state_reg  <= BUSY;
               end
            end
            BUSY: begin
               // Flush wins over a result arriving in the same cycle.
               if (flush_i) begin
                  start_reg <= DIV_STOP;
                  state_reg <= IDLE;
               end else if (div_ready_i == DIV_RESULT_READY) begin
                  hi_reg    <= div_result_i[2*WIDTH-1:WIDTH];
                  lo_reg    <= div_result_i[WIDTH-1:0];
                  start_reg <= DIV_STOP;
                  state_reg <= DONE;
               end else begin
                  if (cnt_reg == CNT_MAX) begin
                     timeout_reg <= 1'b1;
                  end
                  if (cnt_reg != CNT_MAX) begin
                     cnt_reg <= cnt_reg + 1'b1;
                  end
               end
            end
            DONE: begin
               // EX advances at the end of this cycle; the same DIV is never restarted.
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // Stall while accepting (so EX holds the DIV) and for the whole busy period.
   assign stall_req_o = !rst && ((state_reg == IDLE && req_i && !flush_i) ||
                                 (state_reg == BUSY));

   // Write strobe in DONE unless the instruction is being flushed.
   assign hilo_we_o   = !rst && (state_reg == DONE) && !flush_i;

   // Abort the divider when a flush hits an in-flight divide.
   assign div_flush_o = !rst && (state_reg == BUSY) && flush_i;

   assign hi_o          = hi_reg;
   assign lo_o          = lo_reg;
   assign div_start_o   = start_reg;
   assign div_signed_o  = signed_reg;
   assign div_op1_o     = op1_reg;
   assign div_op2_o     = op2_reg;
   assign div_timeout_o = timeout_reg;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl paired with a behavioural iterative divider.
module tb_div_issue_ctrl;

   localparam int TIMEOUT  = 40;
   localparam int DIV_LAT  = 34;
   localparam int FLUSH_AT = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_i;
   logic        signed_i;
   logic [31:0] rs_i;
   logic [31:0] rt_i;
   logic        flush_i;
   logic        stall_req_o;
   logic        hilo_we_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic        div_start_o;
   logic        div_flush_o;
   logic        div_signed_o;
   logic [31:0] div_op1_o;
   logic [31:0] div_op2_o;
   logic [63:0] div_res;
   logic        div_rdy;
   logic        div_timeout_o;

   int total = 0;
   int bad   = 0;

   div_issue_ctrl #(.TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_i        (req_i),
      .signed_i     (signed_i),
      .rs_i         (rs_i),
      .rt_i         (rt_i),
      .flush_i      (flush_i),
      .stall_req_o  (stall_req_o),
      .hilo_we_o    (hilo_we_o),
      .hi_o         (hi_o),
      .lo_o         (lo_o),
      .div_start_o  (div_start_o),
      .div_flush_o  (div_flush_o),
      .div_signed_o (div_signed_o),
      .div_op1_o    (div_op1_o),
      .div_op2_o    (div_op2_o),
      .div_result_i (div_res),
      .div_ready_i  (div_rdy),
      .div_timeout_o(div_timeout_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Shift-subtract divider on magnitudes with sign fix-up; x/0 gives 0.
   function automatic logic [63:0] hw_divide(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] ma, mb, q, rem;
      logic        neg_q, neg_r;
      logic [32:0] t;
      if (b == 32'd0) return 64'd0;
      neg_r = sgn && a[31];
      neg_q = sgn && (a[31] ^ b[31]);
      ma    = neg_r ? -a : a;
      mb    = (sgn && b[31]) ? -b : b;
      rem   = 32'd0;
      q     = 32'd0;
      for (int i = 31; i >= 0; i--) begin
         t = {rem, ma[i]};
         if (t >= {1'b0, mb}) begin
            t    = t - {1'b0, mb};
            q[i] = 1'b1;
         end
         rem = t[31:0];
      end
      if (neg_q) q = -q;
      if (neg_r) rem = -rem;
      return {rem, q};
   endfunction

   // Architectural HI/LO result from language division operators.
   function automatic logic [63:0] arch_divide(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      int          sq, sr;
      logic [31:0] uq, ur;
      if (b == 32'd0) return 64'd0;
      if (sgn) begin
         sq = $signed(a) / $signed(b);
         sr = $signed(a) % $signed(b);
         return {32'(sr), 32'(sq)};
      end
      uq = a / b;
      ur = a % b;
      return {ur, uq};
   endfunction

   // Behavioural divider: answers DIV_LAT cycles after start, holds ready while start is high.
   logic div_never = 1'b0;
   int   dv_cnt    = 0;
   always @(posedge clk) begin
      if (rst || div_flush_o || !div_start_o) begin
         dv_cnt  <= 0;
         div_rdy <= 1'b0;
      end else if (!div_rdy && !div_never) begin
         if (dv_cnt == DIV_LAT - 1) begin
            div_res <= hw_divide(div_signed_o, div_op1_o, div_op2_o);
            div_rdy <= 1'b1;
         end else begin
            dv_cnt <= dv_cnt + 1;
         end
      end
   end

   // Transaction model: one outstanding divide, its expected result and its waiting time.
   bit          m_busy = 1'b0;
   bit          m_done = 1'b0;
   bit          m_timeout = 1'b0;
   int          m_wait = 0;
   logic        m_sgn;
   logic [31:0] m_a, m_b;
   logic [63:0] m_res;
   bit          rst_prev = 1'b0;
   int          we_count = 0;
   int          flush_count = 0;
   logic [31:0] last_hi = 32'd0, last_lo = 32'd0;

   // Per-cycle compare against the model, then advance the model to the next cycle.
   always @(negedge clk) begin
      if (rst) begin
         if (rst_prev) begin
            check("rst_stall",   64'(stall_req_o),   64'd0);
            check("rst_we",      64'(hilo_we_o),     64'd0);
            check("rst_start",   64'(div_start_o),   64'd0);
            check("rst_dflush",  64'(div_flush_o),   64'd0);
            check("rst_timeout", 64'(div_timeout_o), 64'd0);
            check("rst_hilo",    {hi_o, lo_o},       64'd0);
            check("rst_ops",     {div_op1_o, div_op2_o}, 64'd0);
         end
         m_busy = 1'b0; m_done = 1'b0; m_timeout = 1'b0; m_wait = 0;
         rst_prev = 1'b1;
      end else begin
         rst_prev = 1'b0;
         check("stall",   64'(stall_req_o),   64'(m_busy || (!m_busy && !m_done && req_i && !flush_i)));
         check("we",      64'(hilo_we_o),     64'(m_done && !flush_i));
         check("dflush",  64'(div_flush_o),   64'(m_busy && flush_i));
         check("start",   64'(div_start_o),   64'(m_busy));
         check("timeout", 64'(div_timeout_o), 64'(m_timeout));
         if (m_busy) begin
            check("op_sign", 64'(div_signed_o), 64'(m_sgn));
            check("op_ab",   {div_op1_o, div_op2_o}, {m_a, m_b});
         end
         if (m_done && !flush_i) check("hilo", {hi_o, lo_o}, m_res);
         if (hilo_we_o) begin
            we_count++;
            last_hi = hi_o;
            last_lo = lo_o;
         end
         if (div_flush_o) flush_count++;

         if (m_done) begin
            m_done = 1'b0;
         end else if (m_busy) begin
            if (flush_i) begin
               m_busy = 1'b0;
            end else if (div_rdy) begin
               m_busy = 1'b0;
               m_done = 1'b1;
            end else begin
               m_wait++;
               if (m_wait > TIMEOUT) m_timeout = 1'b1;
            end
         end else if (req_i && !flush_i) begin
            m_busy = 1'b1;
            m_sgn  = signed_i;
            m_a    = rs_i;
            m_b    = rt_i;
            m_res  = arch_divide(signed_i, rs_i, rt_i);
            m_wait = 0;
         end
      end
   end

   // One DIV/DIVU from EX. mode 0: normal; 1: flush at busy cycle FLUSH_AT;
   // 2: flush together with ready; 3: flush during the write cycle.
   task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input int mode, input logic [31:0] lit_lo, input logic [31:0] lit_hi,
                          input string tag);
      int w0, f0, n;
      bit fin, seen_rdy;
      w0 = we_count; f0 = flush_count; n = 0; fin = 1'b0; seen_rdy = 1'b0;
      req_i = 1'b1; signed_i = sgn; rs_i = a; rt_i = b;
      while (!fin && n < 80) begin
         @(posedge clk); #1;
         n++;
         if (flush_i) begin
            flush_i = 1'b0; req_i = 1'b0; fin = 1'b1;
         end else begin
            case (mode)
               0: if (we_count != w0) begin req_i = 1'b0; fin = 1'b1; end
               1: if (n == FLUSH_AT + 1) flush_i = 1'b1;
               2: if (div_rdy) flush_i = 1'b1;
               default: begin
                  if (seen_rdy) flush_i = 1'b1;
                  else if (div_rdy) seen_rdy = 1'b1;
               end
            endcase
         end
      end
      check({tag, "_finished"}, 64'(fin), 64'd1);
      if (mode == 0) begin
         check({tag, "_writes"}, 64'(we_count - w0), 64'd1);
         check({tag, "_lo"}, 64'(last_lo), 64'(lit_lo));
         check({tag, "_hi"}, 64'(last_hi), 64'(lit_hi));
      end else begin
         check({tag, "_writes"}, 64'(we_count - w0), 64'd0);
         check({tag, "_aborts"}, 64'(flush_count - f0), (mode == 3) ? 64'd0 : 64'd1);
      end
      $display("div %s sgn=%0d a=0x%08h b=0x%08h mode=%0d lo=0x%08h hi=0x%08h cycles=%0d",
               tag, sgn, a, b, mode, last_lo, last_hi, n);
   endtask

   initial begin
      int w0;
      rst = 1'b1; req_i = 1'b0; signed_i = 1'b0; rs_i = '0; rt_i = '0; flush_i = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      run_div(1'b0, 32'd100, 32'd7, 0, 32'd14, 32'd2, "divu_100_7");
      run_div(1'b1, 32'hFFFFFFF9, 32'd2, 0, 32'hFFFFFFFD, 32'hFFFFFFFF, "div_m7_2");
      run_div(1'b1, 32'd7, 32'hFFFFFFFE, 0, 32'hFFFFFFFD, 32'd1, "div_7_m2");
      run_div(1'b0, 32'd5, 32'd0, 0, 32'd0, 32'd0, "divu_5_0");
      check("divzero_timeout", 64'(div_timeout_o), 64'd0);
      run_div(1'b1, 32'd9, 32'd3, 1, 32'd0, 32'd0, "div_9_3_flush");
      @(posedge clk); #1;
      run_div(1'b1, 32'd9, 32'd3, 0, 32'd3, 32'd0, "div_9_3");
      run_div(1'b0, 32'd20, 32'd4, 0, 32'd5, 32'd0, "divu_20_4");
      run_div(1'b0, 32'd21, 32'd4, 0, 32'd5, 32'd1, "divu_21_4");
      run_div(1'b1, 32'd100, 32'hFFFFFFFD, 2, 32'd0, 32'd0, "flush_with_ready");
      run_div(1'b0, 32'd50, 32'd6, 3, 32'd0, 32'd0, "flush_in_write");

      // Request killed by flush in the same cycle is never accepted.
      req_i = 1'b1; flush_i = 1'b1;
      @(posedge clk); #1;
      req_i = 1'b0; flush_i = 1'b0;
      check("req_flush_no_start", 64'(div_start_o), 64'd0);
      $display("idle req with flush: start=%0d", div_start_o);
      @(posedge clk); #1;

      // Divider that never answers: watchdog, then reset mid-operation.
      div_never = 1'b1;
      w0 = we_count;
      req_i = 1'b1; signed_i = 1'b0; rs_i = 32'd77; rt_i = 32'd7;
      for (int n = 1; n <= TIMEOUT + 4; n++) begin
         @(posedge clk); #1;
         if (n == TIMEOUT + 1) check("timeout_before", 64'(div_timeout_o), 64'd0);
         if (n == TIMEOUT + 2) check("timeout_set", 64'(div_timeout_o), 64'd1);
      end
      check("timeout_sticky", 64'(div_timeout_o), 64'd1);
      check("timeout_stall", 64'(stall_req_o), 64'd1);
      $display("stuck divider: timeout=%0d stall=%0d", div_timeout_o, stall_req_o);
      rst = 1'b1; req_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("timeout_cleared", 64'(div_timeout_o), 64'd0);
      check("rst_midop_start", 64'(div_start_o), 64'd0);
      check("rst_midop_nowrite", 64'(we_count - w0), 64'd0);
      $display("reset mid-op: timeout=%0d start=%0d", div_timeout_o, div_start_o);
      rst = 1'b0; div_never = 1'b0;
      @(posedge clk); #1;

      run_div(1'b0, 32'd1000, 32'd10, 0, 32'd100, 32'd0, "divu_after_rst");

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule
